// File: rtl/wb_bus_tracer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : wb_bus_tracer                                                    |
// | Purpose : Passive Wishbone B4 pipelined master-bus monitor. Each finished  |
// |           transaction goes into a trace FIFO. Firmware drains the FIFO     |
// |           through a 4-word Wishbone slave register port.                   |
// | Options : define WB_TRACER_IRQ_EN to build the registered trace interrupt  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module wb_bus_tracer #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] mon_adr_i,
  input  logic [3:0]  mon_sel_i,
  input  logic        mon_we_i,
  input  logic        mon_cyc_i,
  input  logic        mon_stb_i,
  input  logic        mon_stall_i,
  input  logic        mon_ack_i,
  input  logic        mon_err_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [1:0]  wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_stall_o,
  output logic        irq_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [0:0]    C_S_IDLE  = 1'b0;
  localparam logic [0:0]    C_S_BUSY  = 1'b1;
  localparam logic [15:0]   C_TIMEOUT = 16'(TIMEOUT);
  localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);

  logic [0:0]    state_q, state_d;
  logic [31:0]   adr_q, adr_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [15:0]   lat_q, lat_d;
  logic          enable_q, enable_d;
  logic          overflow_q, overflow_d;
  logic          overlap_q, overlap_d;
  logic [15:0]   drops_q, drops_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ack_q, ack_d;
  logic [31:0]   dat_q, dat_d;
  logic [31:0]   fifo_a_q [DEPTH];
  logic [31:0]   fifo_b_q [DEPTH];

  logic          reg_req, ctrl_wr, clear, accept;
  logic          busy, done, start, overlap_hit;
  logic          st_err, st_abort, st_timeout;
  logic          pop, push, drop_full;
  logic [31:0]   entry_b;
  logic [8:0]    count_ext;
  logic [7:0]    count8;
  logic          unused_dat;

  assign reg_req     = wbs_cyc_i & wbs_stb_i;
  assign ctrl_wr     = reg_req & wbs_we_i & (wbs_adr_i == 2'd0);
  assign clear       = ctrl_wr & wbs_dat_i[1];
  assign accept      = enable_q & mon_cyc_i & mon_stb_i & ~mon_stall_i;
  assign wbs_stall_o = 1'b0;
  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign unused_dat  = &{1'b0, wbs_dat_i[31:2]};
  assign entry_b     = {lat_q, 8'h00, sel_q, we_q, st_abort, st_timeout, st_err};
  // A 256-deep FIFO holds 256 entries; the 8-bit status field saturates there
  assign count_ext   = 9'(count_q);
  assign count8      = count_ext[8] ? 8'hFF : count_ext[7:0];

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state: clear overrides; a same-cycle accept keeps us BUSY
  always_comb begin
    state_d = state_q;
    if (clear)      state_d = C_S_IDLE;
    else if (start) state_d = C_S_BUSY;
    else if (done)  state_d = C_S_IDLE;
  end

  // FSM outputs: completion cause (err > ack > abort > timeout), start, overlap
  always_comb begin
    busy        = (state_q == C_S_BUSY);
    done        = 1'b0;
    start       = 1'b0;
    overlap_hit = 1'b0;
    st_err      = 1'b0;
    st_abort    = 1'b0;
    st_timeout  = 1'b0;
    if (busy) begin
      st_err     = mon_err_i;
      st_abort   = ~mon_err_i & ~mon_ack_i & ~mon_cyc_i;
      st_timeout = ~mon_err_i & ~mon_ack_i & mon_cyc_i & (lat_q == C_TIMEOUT);
      done       = mon_err_i | mon_ack_i | ~mon_cyc_i | (lat_q == C_TIMEOUT);
    end
    if (!clear) begin
      start       = accept & (~busy | done);
      overlap_hit = accept & busy & ~done;
    end
  end

  // Transaction capture; latency reads 1 in the cycle after the accept
  always_comb begin
    adr_d = adr_q;
    sel_d = sel_q;
    we_d  = we_q;
    lat_d = lat_q;
    if (start) begin
      adr_d = mon_adr_i;
      sel_d = mon_sel_i;
      we_d  = mon_we_i;
      lat_d = 16'd1;
    end else if (busy) begin
      lat_d = lat_q + 16'd1;
    end
  end

  // FIFO bookkeeping: a pop frees a slot for a same-cycle push even when full
  always_comb begin
    pop        = reg_req & ~wbs_we_i & (wbs_adr_i == 2'd2) & (count_q != '0);
    push       = done & ~clear & ((count_q != C_DEPTH) | pop);
    drop_full  = done & ~clear & ~push;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | drop_full;
    overlap_d  = overlap_q | overlap_hit;
    drops_d    = drops_q;
    if ((drop_full | overlap_hit) && (drops_q != 16'hFFFF)) drops_d = drops_q + 16'd1;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      overlap_d  = 1'b0;
      drops_d    = 16'd0;
    end
  end

  // Register port: single-cycle ack, read data registered alongside it
  always_comb begin
    enable_d = ctrl_wr ? wbs_dat_i[0] : enable_q;
    ack_d    = reg_req;
    dat_d    = 32'd0;
    if (reg_req && !wbs_we_i) begin
      case (wbs_adr_i)
        2'd0: dat_d = {16'd0, count8, 3'd0, busy, overlap_q, overflow_q, 1'b0, enable_q};
        2'd1: dat_d = (count_q != '0) ? fifo_a_q[rd_ptr_q] : 32'd0;
        2'd2: dat_d = (count_q != '0) ? fifo_b_q[rd_ptr_q] : 32'd0;
        default: dat_d = {16'd0, drops_q};
      endcase
    end
  end

  // Control and status flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      adr_q      <= 32'd0;
      sel_q      <= 4'd0;
      we_q       <= 1'b0;
      lat_q      <= 16'd0;
      enable_q   <= 1'b0;
      overflow_q <= 1'b0;
      overlap_q  <= 1'b0;
      drops_q    <= 16'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ack_q      <= 1'b0;
      dat_q      <= 32'd0;
    end else begin
      adr_q      <= adr_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      lat_q      <= lat_d;
      enable_q   <= enable_d;
      overflow_q <= overflow_d;
      overlap_q  <= overlap_d;
      drops_q    <= drops_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
    end
  end

  // Trace storage; contents are only meaningful below count, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a_q[wr_ptr_q] <= adr_q;
      fifo_b_q[wr_ptr_q] <= entry_b;
    end
  end

`ifdef WB_TRACER_IRQ_EN
  localparam logic [CW-1:0] C_HALF = CW'(DEPTH / 2);
  logic irq_q, irq_d;

  // Interrupt when the FIFO is half full or something was lost
  always_comb irq_d = (count_q >= C_HALF) | overflow_q;

  // Interrupt register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq_o = irq_q;
`else
  assign irq_o = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_tracer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module  : tb_wb_bus_tracer                                                 |
// | Purpose : Directed plus randomized bench for wb_bus_tracer against a       |
// |           queue-based transaction-level reference model.                   |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_wb_bus_tracer;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mon_adr_i = '0;
  logic [3:0]  mon_sel_i = '0;
  logic        mon_we_i = 0, mon_cyc_i = 0, mon_stb_i = 0;
  logic        mon_stall_i = 0, mon_ack_i = 0, mon_err_i = 0;
  logic        wbs_cyc_i = 0, wbs_stb_i = 0, wbs_we_i = 0;
  logic [1:0]  wbs_adr_i = '0;
  logic [31:0] wbs_dat_i = '0;
  logic [31:0] wbs_dat_o;
  logic        wbs_ack_o, wbs_stall_o, irq_o;

  wb_bus_tracer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .mon_adr_i(mon_adr_i), .mon_sel_i(mon_sel_i), .mon_we_i(mon_we_i),
    .mon_cyc_i(mon_cyc_i), .mon_stb_i(mon_stb_i), .mon_stall_i(mon_stall_i),
    .mon_ack_i(mon_ack_i), .mon_err_i(mon_err_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
    .wbs_ack_o(wbs_ack_o), .wbs_stall_o(wbs_stall_o), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: trace FIFO as queues of entries --------
  logic [31:0] q_a[$];
  logic [31:0] q_b[$];
  bit          m_en, m_ovf, m_ovl, m_trk;
  int          m_drops, m_acc_cyc, cyc_n;
  logic [31:0] m_adr;
  logic [3:0]  m_sel;
  bit          m_we;
  bit          m_ack, m_rd, m_irq;
  logic [31:0] m_dat;

  task automatic model_reset();
    q_a.delete(); q_b.delete();
    m_en = 0; m_ovf = 0; m_ovl = 0; m_trk = 0; m_drops = 0;
    m_ack = 0; m_rd = 0; m_irq = 0; m_dat = '0;
  endtask

  task automatic bump_drops();
    if (m_drops < 65535) m_drops++;
  endtask

  // Consequences of the current cycle's inputs, as seen after the next edge
  task automatic model_step();
    bit          req, clr, pop, comp, acc, new_en, irq_next, e_err, e_abort, e_to;
    logic [31:0] rdv;
    logic [7:0]  cnt8;
    int          lat;
    req = wbs_cyc_i && wbs_stb_i;
    clr = 0; pop = 0; comp = 0; rdv = '0;
    cnt8 = (q_a.size() > 255) ? 8'hFF : 8'(q_a.size());
    if (req && !wbs_we_i) begin
      case (wbs_adr_i)
        2'd0: rdv = {16'h0, cnt8, 3'b0, m_trk, m_ovl, m_ovf, 1'b0, m_en};
        2'd1: rdv = (q_a.size() != 0) ? q_a[0] : 32'd0;
        2'd2: if (q_b.size() != 0) begin rdv = q_b[0]; pop = 1; end
        default: rdv = 32'(m_drops);
      endcase
    end
    new_en = m_en;
    if (req && wbs_we_i && wbs_adr_i == 2'd0) begin
      new_en = wbs_dat_i[0];
      clr    = wbs_dat_i[1];
    end
`ifdef WB_TRACER_IRQ_EN
    irq_next = (q_a.size() >= DEPTH / 2) || m_ovf;
`else
    irq_next = 0;
`endif
    acc = m_en && mon_cyc_i && mon_stb_i && !mon_stall_i;
    lat = cyc_n - m_acc_cyc;
    if (m_trk) comp = mon_err_i || mon_ack_i || !mon_cyc_i || (lat == TIMEOUT);
    if (pop) begin void'(q_a.pop_front()); void'(q_b.pop_front()); end
    if (clr) begin
      q_a.delete(); q_b.delete();
      m_ovf = 0; m_ovl = 0; m_drops = 0; m_trk = 0;
    end else begin
      if (comp) begin
        e_err   = mon_err_i;
        e_abort = !mon_err_i && !mon_ack_i && !mon_cyc_i;
        e_to    = !mon_err_i && !mon_ack_i && mon_cyc_i && (lat == TIMEOUT);
        if (q_a.size() < DEPTH) begin
          q_a.push_back(m_adr);
          q_b.push_back({16'(lat), 8'h00, m_sel, m_we, e_abort, e_to, e_err});
        end else begin
          m_ovf = 1; bump_drops();
        end
      end else if (m_trk && acc) begin
        m_ovl = 1; bump_drops();
      end
      if (acc && (!m_trk || comp)) begin
        m_trk = 1; m_adr = mon_adr_i; m_sel = mon_sel_i; m_we = mon_we_i;
        m_acc_cyc = cyc_n;
      end else if (comp) begin
        m_trk = 0;
      end
    end
    m_en = new_en; m_ack = req; m_rd = req && !wbs_we_i; m_dat = rdv; m_irq = irq_next;
    cyc_n++;
  endtask

  // One clock: predict, advance, compare outputs 1 ns after the edge
  task automatic step();
    model_step();
    @(posedge clk); #1;
    check("ack", 32'(wbs_ack_o), 32'(m_ack));
    if (m_rd) check("rdata", wbs_dat_o, m_dat);
    check("irq", 32'(irq_o), 32'(m_irq));
  endtask

  task automatic mon_idle();
    mon_cyc_i = 0; mon_stb_i = 0; mon_we_i = 0; mon_stall_i = 0;
    mon_ack_i = 0; mon_err_i = 0; mon_adr_i = '0; mon_sel_i = '0;
  endtask

  task automatic reg_idle();
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_adr_i = '0; wbs_dat_i = '0;
  endtask

  task automatic reg_rd(input logic [1:0] idx, output logic [31:0] d);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 0; wbs_adr_i = idx;
    step();
    d = wbs_dat_o;
    reg_idle();
  endtask

  task automatic reg_wr(input logic [1:0] idx, input logic [31:0] v);
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = idx; wbs_dat_i = v;
    step();
    reg_idle();
  endtask

  task automatic mon_start(input logic [31:0] a, input logic [3:0] s, input logic w);
    mon_cyc_i = 1; mon_stb_i = 1; mon_adr_i = a; mon_sel_i = s; mon_we_i = w;
    mon_ack_i = 0; mon_err_i = 0; mon_stall_i = 0;
  endtask

  task automatic random_drive();
    mon_cyc_i   = ($urandom_range(0, 9) != 0);
    mon_stb_i   = mon_cyc_i && ($urandom_range(0, 1) == 1);
    mon_stall_i = ($urandom_range(0, 3) == 0);
    mon_we_i    = ($urandom_range(0, 1) == 1);
    mon_adr_i   = $urandom;
    mon_sel_i   = 4'($urandom_range(0, 15));
    mon_ack_i   = ($urandom_range(0, 9) < 3);
    mon_err_i   = ($urandom_range(0, 19) == 0);
    if ($urandom_range(0, 9) < 3) begin
      wbs_cyc_i = 1; wbs_stb_i = 1;
      wbs_adr_i = 2'($urandom_range(0, 3));
      wbs_we_i  = ($urandom_range(0, 4) == 0);
      wbs_dat_i = $urandom;
      wbs_dat_i[0] = ($urandom_range(0, 9) != 0);
      wbs_dat_i[1] = ($urandom_range(0, 19) == 0);
    end else begin
      reg_idle();
    end
  endtask

  initial begin
    logic [31:0] d;
    model_reset();
    cyc_n = 0; m_acc_cyc = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'd0);
    check("rst_dat", wbs_dat_o, 32'd0);
    check("rst_irq", 32'(irq_o), 32'd0);
    rst = 1'b0;
    reg_rd(2'd0, d); check("rst_status", d, 32'h0000_0000);
    reg_rd(2'd3, d); check("rst_drops", d, 32'h0000_0000);

    // Basic read, ack one cycle after accept
    reg_wr(2'd0, 32'h1);
    mon_start(32'h0000_0010, 4'hF, 1'b0); step();
    mon_stb_i = 0; mon_ack_i = 1; step();
    mon_idle(); step();
    reg_rd(2'd1, d); check("basic_adr", d, 32'h0000_0010);
    reg_rd(2'd2, d); check("basic_info", d, 32'h0001_00F0);
    reg_rd(2'd0, d); check("basic_count", 32'(d[15:8]), 32'd0);

    // Error write after three cycles
    mon_start(32'h8000_0004, 4'h3, 1'b1); step();
    mon_stb_i = 0; step(); step();
    mon_err_i = 1; step();
    mon_idle(); step();
    reg_rd(2'd2, d); check("err_info", d, 32'h0003_0039);

    // Timeout with a late ack at cycle 12
    mon_start(32'h0000_0020, 4'hF, 1'b0); step();
    mon_stb_i = 0; repeat (11) step();
    mon_ack_i = 1; step();
    mon_idle(); step();
    reg_rd(2'd0, d); check("to_count", 32'(d[15:8]), 32'd1);
    reg_rd(2'd2, d); check("to_info", d, 32'h0008_00F2);
    reg_rd(2'd0, d); check("to_count_after", 32'(d[15:8]), 32'd0);

    // Back-to-back pipelined requests
    mon_start(32'h0000_0100, 4'hF, 1'b0); step();
    mon_adr_i = 32'h0000_0104; mon_ack_i = 1; step();
    mon_stb_i = 0; step();
    mon_idle(); step();
    reg_rd(2'd0, d); check("b2b_status", d, 32'h0000_0201);
    reg_rd(2'd1, d); check("b2b_adr0", d, 32'h0000_0100);
    reg_rd(2'd2, d); check("b2b_info0", d, 32'h0001_00F0);
    reg_rd(2'd1, d); check("b2b_adr1", d, 32'h0000_0104);
    reg_rd(2'd2, d); check("b2b_info1", d, 32'h0001_00F0);

    // Overflow: six completions into a 4-deep FIFO
    mon_start(32'h0000_0200, 4'hF, 1'b0);
    for (int i = 0; i < 6; i++) begin
      mon_adr_i = 32'h200 + 32'(i * 4);
      mon_ack_i = (i > 0);
      step();
    end
    mon_stb_i = 0; mon_ack_i = 1; step();
    mon_idle(); step();
    reg_rd(2'd0, d); check("ovf_status", d, 32'h0000_0405);
    reg_rd(2'd3, d); check("ovf_drops", d, 32'd2);
`ifdef WB_TRACER_IRQ_EN
    check("ovf_irq", 32'(irq_o), 32'd1);
`else
    check("ovf_irq", 32'(irq_o), 32'd0);
`endif

    // Clear in the same cycle as a completion that would have been pushed
    reg_rd(2'd2, d);
    mon_start(32'h0000_0300, 4'hF, 1'b0); step();
    mon_stb_i = 0; mon_ack_i = 1;
    wbs_cyc_i = 1; wbs_stb_i = 1; wbs_we_i = 1; wbs_adr_i = 2'd0; wbs_dat_i = 32'h3;
    step();
    reg_idle(); mon_idle(); step();
    reg_rd(2'd0, d); check("clr_status", d, 32'h0000_0001);
    reg_rd(2'd3, d); check("clr_drops", d, 32'd0);

    // Randomized traffic with one asynchronous reset in the middle
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        random_drive();
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_ack", 32'(wbs_ack_o), 32'd0);
        check("mid_rst_dat", wbs_dat_o, 32'd0);
        check("mid_rst_irq", 32'(irq_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
      random_drive();
      step();
    end

    mon_idle(); reg_idle(); step();
    reg_rd(2'd0, d);
    reg_rd(2'd3, d);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete (checks %0d)", n_checks);
    $fatal(1, "time bound expired");
  end

endmodule
`default_nettype wire
